// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: ALU operation codes, major opcodes,
// immediate format selector and the decoded control word.
package rv32_pkg;

    localparam logic [5:0] ALU_ADD   = 6'h00;
    localparam logic [5:0] ALU_SUB   = 6'h01;
    localparam logic [5:0] ALU_SLL   = 6'h02;
    localparam logic [5:0] ALU_SLT   = 6'h03;
    localparam logic [5:0] ALU_SLTU  = 6'h04;
    localparam logic [5:0] ALU_XOR   = 6'h05;
    localparam logic [5:0] ALU_SRL   = 6'h06;
    localparam logic [5:0] ALU_SRA   = 6'h07;
    localparam logic [5:0] ALU_OR    = 6'h08;
    localparam logic [5:0] ALU_AND   = 6'h09;
    localparam logic [5:0] ALU_ADDI  = 6'h0A;
    localparam logic [5:0] ALU_SLLI  = 6'h0B;
    localparam logic [5:0] ALU_SLTI  = 6'h0C;
    localparam logic [5:0] ALU_SLTIU = 6'h0D;
    localparam logic [5:0] ALU_XORI  = 6'h0E;
    localparam logic [5:0] ALU_SRLI  = 6'h0F;
    localparam logic [5:0] ALU_ORI   = 6'h10;
    localparam logic [5:0] ALU_ANDI  = 6'h11;
    localparam logic [5:0] ALU_LUI   = 6'h12;
    localparam logic [5:0] ALU_SB    = 6'h17;
    localparam logic [5:0] ALU_SH    = 6'h18;
    localparam logic [5:0] ALU_SW    = 6'h19;
    localparam logic [5:0] ALU_BEQ   = 6'h1A;
    localparam logic [5:0] ALU_BNE   = 6'h1B;
    localparam logic [5:0] ALU_BLT   = 6'h1C;
    localparam logic [5:0] ALU_BGE   = 6'h1D;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U
    } imm_fmt_e;

    typedef struct packed {
        logic [5:0]  alu_cntrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm_val;
        logic [4:0]  shift_amount;
        logic        reg_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        is_branch;
        logic        illegal;
    } decode_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the I, S, B and U formats. U immediates stay
// unshifted because the ALU applies the <<12 itself.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;

    always_comb begin
        imm_i = instr[31:20];
        imm_s = {instr[31:25], instr[11:7]};
        imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm   = '0;
        case (fmt)
            IMM_I: imm = 32'(imm_i);
            IMM_S: imm = 32'(imm_s);
            IMM_B: imm = 32'(imm_b);
            IMM_U: imm = {12'b0, instr[31:12]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// RV32I decode stage: combinational decode into a control word, held in a
// one-entry output register with valid/ready handshake, flush and counter.
module instr_decoder
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [5:0]       alu_cntrl,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm_val,
    output logic [4:0]       shift_amount,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             is_branch,
    output logic             illegal,
    output logic [CNT_W-1:0] decode_count
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    logic        legal;
    decode_t     dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        dec   = '0;
        fmt   = IMM_I;
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                legal = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0: dec.alu_cntrl = ALU_ADD;
                        3'd1: dec.alu_cntrl = ALU_SLL;
                        3'd2: dec.alu_cntrl = ALU_SLT;
                        3'd3: dec.alu_cntrl = ALU_SLTU;
                        3'd4: dec.alu_cntrl = ALU_XOR;
                        3'd5: dec.alu_cntrl = ALU_SRL;
                        3'd6: dec.alu_cntrl = ALU_OR;
                        default: dec.alu_cntrl = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    dec.alu_cntrl = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    dec.alu_cntrl = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
                dec.rd  = in_instr[11:7];
                dec.reg_we = 1'b1;
            end
            OP_I: begin
                legal = 1'b1;
                case (funct3)
                    3'd0: dec.alu_cntrl = ALU_ADDI;
                    3'd2: dec.alu_cntrl = ALU_SLTI;
                    3'd3: dec.alu_cntrl = ALU_SLTIU;
                    3'd4: dec.alu_cntrl = ALU_XORI;
                    3'd6: dec.alu_cntrl = ALU_ORI;
                    3'd7: dec.alu_cntrl = ALU_ANDI;
                    3'd1: dec.alu_cntrl = ALU_SLLI;
                    default: dec.alu_cntrl = ALU_SRLI;
                endcase
                // Shift-immediates carry funct7 in the upper immediate bits; SRAI is unsupported.
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    dec.shift_amount = in_instr[24:20];
                    legal = (funct7 == 7'b0000000);
                end
                dec.rs1    = in_instr[19:15];
                dec.rd     = in_instr[11:7];
                dec.imm_val = imm;
                dec.reg_we = 1'b1;
            end
            OP_LOAD: begin
                legal         = (funct3 == 3'd2);
                dec.alu_cntrl = ALU_ADDI;
                dec.rs1       = in_instr[19:15];
                dec.rd        = in_instr[11:7];
                dec.imm_val   = imm;
                dec.mem_rd    = 1'b1;
                dec.reg_we    = 1'b1;
            end
            OP_STORE: begin
                fmt   = IMM_S;
                legal = 1'b1;
                case (funct3)
                    3'd0: dec.alu_cntrl = ALU_SB;
                    3'd1: dec.alu_cntrl = ALU_SH;
                    3'd2: dec.alu_cntrl = ALU_SW;
                    default: legal = 1'b0;
                endcase
                dec.rs1     = in_instr[19:15];
                dec.rs2     = in_instr[24:20];
                dec.imm_val = imm;
                dec.mem_wr  = 1'b1;
            end
            OP_BRANCH: begin
                fmt   = IMM_B;
                legal = 1'b1;
                case (funct3)
                    3'd0: dec.alu_cntrl = ALU_BEQ;
                    3'd1: dec.alu_cntrl = ALU_BNE;
                    3'd4: dec.alu_cntrl = ALU_BLT;
                    3'd5: dec.alu_cntrl = ALU_BGE;
                    default: legal = 1'b0;
                endcase
                dec.rs1       = in_instr[19:15];
                dec.rs2       = in_instr[24:20];
                dec.imm_val   = imm;
                dec.is_branch = 1'b1;
            end
            OP_LUI: begin
                fmt           = IMM_U;
                legal         = 1'b1;
                dec.alu_cntrl = ALU_LUI;
                dec.rd        = in_instr[11:7];
                dec.imm_val   = imm;
                dec.reg_we    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // An illegal word carries nothing but the flag, so execute has no side effects.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Output register stage
    logic             out_valid_q, out_valid_d;
    decode_t          dec_q, dec_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic             out_fire;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        dec_d       = dec_q;
        pc_d        = pc_q;
        count_d     = count_q + CNT_W'(out_fire);
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_ready) begin
            out_valid_d = in_valid;
        end
        if (accept) begin
            dec_d = dec;
            pc_d  = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            pc_q        <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = pc_q;
    assign alu_cntrl    = dec_q.alu_cntrl;
    assign rs1          = dec_q.rs1;
    assign rs2          = dec_q.rs2;
    assign rd           = dec_q.rd;
    assign imm_val      = XLEN'(dec_q.imm_val);
    assign shift_amount = dec_q.shift_amount;
    assign reg_we       = dec_q.reg_we;
    assign mem_rd       = dec_q.mem_rd;
    assign mem_wr       = dec_q.mem_wr;
    assign is_branch    = dec_q.is_branch;
    assign illegal      = dec_q.illegal;
    assign decode_count = count_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder with hand-computed expected control words.
module tb_instr_decoder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  alu_cntrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_val;
    logic [4:0]  shift_amount;
    logic        reg_we, mem_rd, mem_wr, is_branch, illegal;
    logic [31:0] decode_count;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_SLLI = 32'h00509093;
    localparam logic [31:0] I_SW   = 32'hFE20AE23;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_LW   = 32'h00812303;
    localparam logic [31:0] I_SUB  = 32'h407302B3;
    localparam logic [31:0] I_BNE  = 32'hFE209EE3;
    localparam logic [31:0] I_SRAI = 32'h4050D093;
    localparam logic [31:0] I_BLTU = 32'h0020E463;

    instr_decoder #(.XLEN(32), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .alu_cntrl    (alu_cntrl),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .imm_val      (imm_val),
        .shift_amount (shift_amount),
        .reg_we       (reg_we),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .is_branch    (is_branch),
        .illegal      (illegal),
        .decode_count (decode_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", decode_count, 0);
        check("rst_alu", alu_cntrl, 0);
        check("rst_rd", rd, 0);
        check("rst_imm", imm_val, 0);
        check("rst_pc", out_pc, 0);
        check("rst_in_ready", in_ready, 1);

        // add x3,x1,x2
        drive(1'b1, I_ADD, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("add_valid", out_valid, 1);
        check("add_alu", alu_cntrl, 6'h00);
        check("add_rs1", rs1, 1);
        check("add_rs2", rs2, 2);
        check("add_rd", rd, 3);
        check("add_we", reg_we, 1);
        check("add_pc", out_pc, 32'h100);
        check("add_cnt_pre", decode_count, 0);
        tick();
        check("add_drain_valid", out_valid, 0);
        check("add_cnt", decode_count, 1);

        // addi then slli back to back
        drive(1'b1, I_ADDI, 32'h104);
        tick();
        drive(1'b1, I_SLLI, 32'h108);
        check("addi_alu", alu_cntrl, 6'h0A);
        check("addi_imm", imm_val, 32'hFFFFFFFF);
        check("addi_rd", rd, 1);
        check("addi_rs1", rs1, 0);
        check("addi_shamt", shift_amount, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("slli_valid", out_valid, 1);
        check("slli_alu", alu_cntrl, 6'h0B);
        check("slli_shamt", shift_amount, 5);
        check("slli_pc", out_pc, 32'h108);
        check("slli_cnt", decode_count, 2);
        tick();
        check("slli_cnt_drain", decode_count, 3);

        // sw then lui
        drive(1'b1, I_SW, 32'h10C);
        tick();
        drive(1'b1, I_LUI, 32'h110);
        check("sw_alu", alu_cntrl, 6'h19);
        check("sw_imm", imm_val, 32'hFFFFFFFC);
        check("sw_memwr", mem_wr, 1);
        check("sw_we", reg_we, 0);
        check("sw_rs1", rs1, 1);
        check("sw_rs2", rs2, 2);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("lui_alu", alu_cntrl, 6'h12);
        check("lui_imm", imm_val, 32'h00012345);
        check("lui_rd", rd, 5);
        check("lui_rs1", rs1, 0);
        check("lui_we", reg_we, 1);
        check("lui_memwr", mem_wr, 0);
        tick();
        check("lui_cnt", decode_count, 5);

        // lw, sub, bne
        drive(1'b1, I_LW, 32'h114);
        tick();
        drive(1'b1, I_SUB, 32'h118);
        check("lw_alu", alu_cntrl, 6'h0A);
        check("lw_memrd", mem_rd, 1);
        check("lw_imm", imm_val, 8);
        check("lw_rd", rd, 6);
        tick();
        drive(1'b1, I_BNE, 32'h11C);
        check("sub_alu", alu_cntrl, 6'h01);
        check("sub_memrd", mem_rd, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("bne_alu", alu_cntrl, 6'h1B);
        check("bne_imm", imm_val, 32'hFFFFFFFC);
        check("bne_branch", is_branch, 1);
        check("bne_we", reg_we, 0);
        check("bne_cnt", decode_count, 7);
        tick();

        // illegal encodings
        drive(1'b1, I_SRAI, 32'h120);
        tick();
        drive(1'b1, I_BLTU, 32'h124);
        check("srai_valid", out_valid, 1);
        check("srai_illegal", illegal, 1);
        check("srai_alu", alu_cntrl, 0);
        check("srai_we", reg_we, 0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("bltu_valid", out_valid, 1);
        check("bltu_illegal", illegal, 1);
        check("bltu_alu", alu_cntrl, 0);
        check("bltu_branch", is_branch, 0);
        tick();
        check("illegal_cnt", decode_count, 10);
        check("illegal_clear", illegal, 1);

        // back-pressure: second instruction waits and is not lost
        out_ready = 1'b0;
        drive(1'b1, I_ADD, 32'h200);
        tick();
        drive(1'b1, I_LUI, 32'h204);
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", out_pc, 32'h200);
            check("stall_alu", alu_cntrl, 6'h00);
            check("stall_rd", rd, 3);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready2", in_ready, 0);
        end
        check("stall_cnt", decode_count, 10);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("release_pc", out_pc, 32'h204);
        check("release_alu", alu_cntrl, 6'h12);
        check("release_cnt", decode_count, 11);
        tick();
        check("release_drain", out_valid, 0);
        check("release_cnt2", decode_count, 12);

        // flush with simultaneous output handshake and incoming instruction
        drive(1'b1, I_ADD, 32'h300);
        tick();
        check("flush_pre_valid", out_valid, 1);
        drive(1'b1, I_LUI, 32'h304);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("flush_valid", out_valid, 0);
        check("flush_cnt", decode_count, 13);
        tick();
        check("flush_dropped", out_valid, 0);
        check("flush_pc_kept", out_pc, 32'h300);

        // reset in the middle of a stall
        out_ready = 1'b0;
        drive(1'b1, I_SW, 32'h400);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("mid_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cnt", decode_count, 0);
        check("mid_rst_alu", alu_cntrl, 0);
        check("mid_rst_memwr", mem_wr, 0);
        check("mid_rst_pc", out_pc, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
